// File: rtl/nf_identifier_regs.sv
// nf_identifier_regs
//   AXI4-Lite identifier/status register block. It serves a parameter-defined
//   table of read-only ID words, a byte-writable scratch register, a 64-bit
//   uptime counter and a saturating error counter. The upper half of the
//   uptime counter is read through a snapshot so the host gets a coherent
//   64-bit value.
//
//   Register map (word index w = addr[C_DECODE_BITS-1:2], N = C_NUM_ID_WORDS):
//     w <  N   ID[w]      RO
//     w == N   SCRATCH    RW, byte strobes
//     w == N+1 UPTIME_LO  RO, reading it snapshots UPTIME[63:32]
//     w == N+2 UPTIME_HI  RO, returns the snapshot
//     w == N+3 ERR_CNT    RO, saturating count of SLVERR responses
//     other    unmapped   SLVERR, RDATA = 0
//
//   FSM states:
//     state  | meaning
//     W_IDLE | waiting for AW and W together; readies pulse on the handshake
//     W_RESP | BVALID held with a stable BRESP until BREADY
//     R_IDLE | waiting for AR; ARREADY pulses on the handshake
//     R_DATA | RVALID held with stable RDATA/RRESP until RREADY
//
//   Ports:
//     S_AXI_ACLK    clock for all logic
//     S_AXI_ARESET  asynchronous active-high reset
//     S_AXI_AW*     write address channel
//     S_AXI_W*      write data channel
//     S_AXI_B*      write response channel
//     S_AXI_AR*     read address channel
//     S_AXI_R*      read data channel
module nf_identifier_regs #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_DECODE_BITS      = 8,
  parameter int C_NUM_ID_WORDS     = 16,
  parameter logic [C_NUM_ID_WORDS*32-1:0] C_ID_WORDS = '0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int WI = C_DECODE_BITS - 2;
  localparam logic [WI-1:0] W_SCR  = WI'(C_NUM_ID_WORDS);
  localparam logic [WI-1:0] W_UPLO = WI'(C_NUM_ID_WORDS + 1);
  localparam logic [WI-1:0] W_UPHI = WI'(C_NUM_ID_WORDS + 2);
  localparam logic [WI-1:0] W_ERR  = WI'(C_NUM_ID_WORDS + 3);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [31:0] scratch;
  logic [63:0] uptime;
  logic [31:0] uptime_hi_snap;
  logic [31:0] err_cnt;

  logic [WI-1:0] w_idx;
  logic [WI-1:0] r_idx;
  logic          wr_hs;
  logic          ar_hs;
  logic          wr_err;
  logic          rd_err;
  logic [31:0]   id_word;
  logic [31:0]   rd_data_nxt;
  logic [1:0]    err_inc;
  logic [32:0]   err_sum;

  // Only the local offset is decoded; the rest of the address is don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:C_DECODE_BITS],
                              S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:C_DECODE_BITS],
                              S_AXI_ARADDR[1:0]};

  assign w_idx = S_AXI_AWADDR[C_DECODE_BITS-1:2];
  assign r_idx = S_AXI_ARADDR[C_DECODE_BITS-1:2];

  // Readies are decoded from state so a write can be accepted every other
  // cycle; they are held low while reset is asserted.
  assign wr_hs = (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_ARESET;
  assign ar_hs = (r_state == R_IDLE) && S_AXI_ARVALID && !S_AXI_ARESET;

  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_ARREADY = ar_hs;

  assign wr_err = (w_idx != W_SCR);

  always_comb begin
    id_word = '0;
    for (int i = 0; i < C_NUM_ID_WORDS; i++) begin
      if (int'(r_idx) == i) id_word = C_ID_WORDS[32*i +: 32];
    end
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_err      = 1'b0;
    if (r_idx < W_SCR)        rd_data_nxt = id_word;
    else if (r_idx == W_SCR)  rd_data_nxt = scratch;
    else if (r_idx == W_UPLO) rd_data_nxt = uptime[31:0];
    else if (r_idx == W_UPHI) rd_data_nxt = uptime_hi_snap;
    else if (r_idx == W_ERR)  rd_data_nxt = err_cnt;
    else                      rd_err      = 1'b1;
  end

  // Both channels can fail in the same cycle, so the increment is 0..2.
  assign err_inc = {1'b0, ar_hs & rd_err} + {1'b0, wr_hs & wr_err};
  assign err_sum = {1'b0, err_cnt} + {31'd0, err_inc};

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state      <= W_IDLE;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (wr_hs) begin
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
          w_state      <= W_RESP;
        end
        W_RESP: if (S_AXI_BREADY) begin
          S_AXI_BVALID <= 1'b0;
          w_state      <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state      <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          S_AXI_RVALID <= 1'b1;
          S_AXI_RDATA  <= rd_data_nxt;
          S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
          r_state      <= R_DATA;
        end
        R_DATA: if (S_AXI_RREADY) begin
          S_AXI_RVALID <= 1'b0;
          r_state      <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      scratch        <= '0;
      uptime         <= '0;
      uptime_hi_snap <= '0;
      err_cnt        <= '0;
    end else begin
      uptime <= uptime + 64'd1;
      if (wr_hs && !wr_err) begin
        for (int b = 0; b < 4; b++) begin
          if (S_AXI_WSTRB[b]) scratch[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
      // Snapshot taken in the same cycle the low word is sampled.
      if (ar_hs && (r_idx == W_UPLO)) uptime_hi_snap <= uptime[63:32];
      err_cnt <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    end
  end

endmodule

// File: doc/nf_identifier_regs.md
Name: nf_identifier_regs

Overview:
- Native AXI4-Lite identifier/status register block: the parametrised successor to the vendor-IP identifier wrapper.
- Serves a parameter-defined table of read-only ID words (project ID, revision, build date, and similar).
- Adds a byte-writable scratch register, a 64-bit uptime counter with atomic snapshot, and an error counter.
- Sits on the control AXI4-Lite interconnect. Host software uses it to identify the bitstream and sanity-check the register path.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, AXI address width. Only bits [C_DECODE_BITS-1:0] are decoded; upper bits are ignored.
- C_S_AXI_DATA_WIDTH, 32, AXI data width. Fixed at 32.
- C_DECODE_BITS, 8, local offset bits. Must satisfy 2^C_DECODE_BITS >= 4*(C_NUM_ID_WORDS+4).
- C_NUM_ID_WORDS, 16, number of read-only ID words, 1..(2^(C_DECODE_BITS-2))-4.
- C_ID_WORDS, 0 (C_NUM_ID_WORDS*32 bits), flattened ID table. Word i is bits [32i+31:32i].

Ports:
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  write byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response (00 OKAY, 10 SLVERR).
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset: every output is 0 (all READY/VALID signals, RDATA, RRESP, BRESP). SCRATCH, UPTIME, UPTIME_HI_SNAP and ERR_CNT are also 0. Async assert; release is sampled on S_AXI_ACLK.
- Register map, word index w = addr[C_DECODE_BITS-1:2]; addr[1:0] is ignored:
  - w < N (N = C_NUM_ID_WORDS): ID[w], read-only.
  - w = N: SCRATCH, RW with byte strobes.
  - w = N+1: UPTIME_LO, RO. Reading it latches UPTIME[63:32] into UPTIME_HI_SNAP in the same cycle.
  - w = N+2: UPTIME_HI, RO. Returns UPTIME_HI_SNAP, not the live counter.
  - w = N+3: ERR_CNT, RO. Saturating 32-bit count of SLVERR responses issued on either channel.
  - w > N+3: unmapped.
- Write channel FSM, states W_IDLE and W_RESP:
  - In W_IDLE, when AWVALID and WVALID are both high, pulse AWREADY and WREADY together for 1 cycle, perform the write, and go to W_RESP.
  - In W_IDLE, never assert either ready alone; AW-only or W-only waits.
  - In W_RESP, BVALID=1 and BRESP is held stable until BREADY, then return to W_IDLE.
  - BVALID rises 1 cycle after the address/data handshake. Back-to-back write throughput is one write per 2 cycles with BREADY tied high.
  - Writes to SCRATCH update only the bytes whose WSTRB bit is set; BRESP=OKAY. A write to SCRATCH with WSTRB=0 returns OKAY and changes nothing.
  - Writes to RO or unmapped words return SLVERR and change no state.
- Read channel FSM, states R_IDLE and R_DATA:
  - In R_IDLE with ARVALID, pulse ARREADY for 1 cycle, register RDATA/RRESP, and go to R_DATA.
  - In R_DATA, RVALID=1 and RDATA/RRESP are stable until RREADY, then return to R_IDLE.
  - Read latency is 1 cycle from the AR handshake to RVALID.
  - Unmapped reads return RDATA=0 with RRESP=SLVERR.
- UPTIME: 64-bit free-running counter, +1 every cycle, wraps 2^64-1 -> 0.
- ERR_CNT:
  - Increments by 1 per SLVERR response and holds at 0xFFFFFFFF.
  - A read SLVERR and a write SLVERR in the same cycle add 2, saturating.
- Simultaneous events:
  - A read and a write of SCRATCH handshaking in the same cycle: the read returns the pre-write value.
  - A read of ERR_CNT in the same cycle as an increment returns the pre-increment value.
- Reset mid-transaction: both FSMs return to IDLE, pending responses are dropped, and VALID signals fall asynchronously.

Test Plan:
- Reset, then read w=0..N-1 -> RDATA equals each C_ID_WORDS slice with RRESP=00. RVALID is high exactly 1 cycle after ARREADY.
- Write SCRATCH 0xDEADBEEF with WSTRB=4'hF, then write 0x00000011 with WSTRB=4'h1, then read -> 0xDEADBE11, BRESP=00 both times.
- Write ID[0] and read w=N+5 -> BRESP=10 and RRESP=10 with RDATA=0, ID[0] unchanged, ERR_CNT reads 2.
- Hold the counter via force at 0x00000000_FFFFFFFE, read UPTIME_LO then UPTIME_HI -> the HI value matches the snapshot taken at the LO read, unaffected by the later carry.
- Hold RREADY/BREADY low for 10 cycles -> RDATA/RRESP/BRESP stable and no new AR/AW accepted. AWVALID without WVALID -> AWREADY stays 0.
- Assert S_AXI_ARESET while BVALID=1 -> BVALID=0 immediately and SCRATCH=0. The next write completes normally.
